placement_checker: RTL



---
 rtl/placement_checker.sv | 136 +++++++++++++
 1 files changed

// File: rtl/placement_checker.sv
// Read-back checker for a finished placement: scans the grid, cross-checks each
// occupied cell against the position RAMs, then recomputes wirelength over the edge ROMs.
module placement_checker #(
  parameter int N      = 5,
  parameter int N_EDGE = 16,
  parameter int W      = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                ok,
  output logic [W-1:0]        placed_cnt,
  output logic [W-1:0]        mismatch_cnt,
  output logic signed [W-1:0] cost,
  output logic                reGrid,
  output logic [W-1:0]        addrGrid,
  input  logic [W-1:0]        doutGrid,
  output logic                rePX,
  output logic [W-1:0]        addrPX,
  input  logic [W-1:0]        doutPX,
  output logic                rePY,
  output logic [W-1:0]        addrPY,
  input  logic [W-1:0]        doutPY,
  output logic                reEA,
  output logic [W-1:0]        addrEA,
  input  logic [W-1:0]        doutEA,
  output logic                reEB,
  output logic [W-1:0]        addrEB,
  input  logic [W-1:0]        doutEB
);
  localparam int NN = N * N;

  typedef enum logic [3:0] {
    IDLE, G_RD, G_WT, G_CHK, P_RD, P_WT, P_CMP,
    E_RD, E_WT, A_RD, A_WT, B_RD, B_WT, ACC, FIN
  } state_t;

  state_t state, cell_next;
  logic [W-1:0] k, row, col, id, eb_id, i, ax, ay, mm_next;
  logic signed [W-1:0] dx, dy, adx, ady, delta;
  logic pos_bad, edge_bad, last_cell, last_edge, cell_adv, to_fin;

  always_comb begin
    pos_bad   = (doutPX != row) || (doutPY != col);
    edge_bad  = (ax == '1) || (ay == '1) || (doutPX == '1) || (doutPY == '1);
    // bx/by are consumed straight off the position RAM outputs in ACC
    dx        = $signed(ax) - $signed(doutPX);
    dy        = $signed(ay) - $signed(doutPY);
    adx       = dx[W-1] ? -dx : dx;
    ady       = dy[W-1] ? -dy : dy;
    delta     = adx + ady - W'(1);
    last_cell = (k == W'(NN - 1));
    last_edge = (i == W'(N_EDGE - 1));
    cell_next = last_cell ? ((N_EDGE == 0) ? FIN : E_RD) : G_RD;
    cell_adv  = ((state == G_CHK) && (doutGrid == '1)) || (state == P_CMP);
    mm_next   = mismatch_cnt;
    if (((state == P_CMP) && pos_bad) || ((state == ACC) && edge_bad))
      mm_next = mismatch_cnt + W'(1);
    to_fin    = (cell_adv && last_cell && (N_EDGE == 0)) || ((state == ACC) && last_edge);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy <= 1'b0; done <= 1'b0; ok <= 1'b0;
      placed_cnt <= '0; mismatch_cnt <= '0; cost <= '0;
      reGrid <= 1'b0; rePX <= 1'b0; rePY <= 1'b0; reEA <= 1'b0; reEB <= 1'b0;
      addrGrid <= '0; addrPX <= '0; addrPY <= '0; addrEA <= '0; addrEB <= '0;
      k <= '0; row <= '0; col <= '0; id <= '0; eb_id <= '0; i <= '0; ax <= '0; ay <= '0;
    end else begin
      reGrid <= 1'b0; rePX <= 1'b0; rePY <= 1'b0; reEA <= 1'b0; reEB <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          placed_cnt <= '0; mismatch_cnt <= '0; cost <= '0; ok <= 1'b0;
          k <= '0; row <= '0; col <= '0; i <= '0;
          busy <= 1'b1;
          state <= G_RD;
        end
        G_RD: begin reGrid <= 1'b1; addrGrid <= k; state <= G_WT; end
        G_WT: state <= G_CHK;
        G_CHK: if (doutGrid == '1) state <= cell_next;
               else begin
                 id <= doutGrid;
                 placed_cnt <= placed_cnt + W'(1);
                 state <= P_RD;
               end
        P_RD: begin
          rePX <= 1'b1; rePY <= 1'b1; addrPX <= id; addrPY <= id;
          state <= P_WT;
        end
        P_WT: state <= P_CMP;
        P_CMP: begin mismatch_cnt <= mm_next; state <= cell_next; end
        E_RD: begin
          reEA <= 1'b1; reEB <= 1'b1; addrEA <= i; addrEB <= i;
          state <= E_WT;
        end
        E_WT: state <= A_RD;
        A_RD: begin
          rePX <= 1'b1; rePY <= 1'b1; addrPX <= doutEA; addrPY <= doutEA;
          eb_id <= doutEB;
          state <= A_WT;
        end
        A_WT: state <= B_RD;
        B_RD: begin
          ax <= doutPX; ay <= doutPY;
          rePX <= 1'b1; rePY <= 1'b1; addrPX <= eb_id; addrPY <= eb_id;
          state <= B_WT;
        end
        B_WT: state <= ACC;
        ACC: begin
          mismatch_cnt <= mm_next;
          if (!edge_bad) cost <= cost + delta;
          i <= i + W'(1);
          state <= last_edge ? FIN : E_RD;
        end
        FIN: state <= IDLE;
        default: state <= IDLE;
      endcase
      // row/col track k/N and k%N so no divider is needed
      if (cell_adv) begin
        k <= k + W'(1);
        if (col == W'(N - 1)) begin col <= '0; row <= row + W'(1); end
        else col <= col + W'(1);
      end
      // ok uses the post-update count so it is valid in the done cycle
      if (to_fin) begin
        done <= 1'b1;
        busy <= 1'b0;
        ok <= (mm_next == '0);
      end
    end
  end
endmodule
